// File: rtl/dup_fifo_pkg.sv
// Shared types and helpers for the duplicate-read FIFO write arbiter.
package dup_fifo_pkg;

  localparam int DW_DEFAULT = 16;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_LOCK = 1'b1
  } arb_state_t;

  // Modular increment with an explicit wrap, so n need not be a power of two.
  function automatic int rr_next(input int idx, input int n);
    return (idx >= n - 1) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/dup_fifo_wr_arb_rr_pick.sv
// rr_pick: purely combinational round-robin winner search.
// Scans ptr, ptr+1, ... (wrapping at N-1) and returns the first requester.
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [IW-1:0] winner,
  output logic          any_valid
);

  logic [IW-1:0] cand [N];

  // Candidate index at each offset from the pointer, wrapped by subtraction.
  for (genvar gi = 0; gi < N; gi++) begin : g_cand
    logic [IW:0] sum;
    assign sum       = {1'b0, ptr} + (IW+1)'(gi);
    assign cand[gi]  = (sum >= (IW+1)'(N)) ? IW'(sum - (IW+1)'(N)) : IW'(sum);
  end

  // Scan from the farthest offset down so the nearest requester wins last.
  always_comb begin
    winner    = '0;
    any_valid = 1'b0;
    for (int k = N - 1; k >= 0; k--) begin
      if (req[cand[k]]) begin
        winner    = cand[k];
        any_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/dup_fifo_wr_arb.sv
// dup_fifo_wr_arb: round-robin write arbiter in front of the duplicate-read FIFO.
// Optional burst lock is compiled in with the macro DUP_ARB_BURST_EN.
module dup_fifo_wr_arb
  import dup_fifo_pkg::*;
#(
  parameter int DW        = DW_DEFAULT,
  parameter int NREQ      = 4,
  parameter int MAX_BURST = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NREQ-1:0]            req_valid,
  input  logic [NREQ-1:0][DW-1:0]    req_data,
  output logic [NREQ-1:0]            req_ready,
  output logic                       fifo_push,
  output logic [DW-1:0]              fifo_write_data,
  input  logic                       fifo_full,
  output logic                       grant_valid,
  output logic [$clog2(NREQ)-1:0]    grant_id
);

  localparam int IW = $clog2(NREQ);

  logic [IW-1:0] rr_ptr_reg, rr_ptr_next;
  logic [IW-1:0] pick_ptr, pick_id;
  logic          pick_any;
  logic [IW-1:0] grant_id_raw, grant_inc;
  logic          grant_raw;

  rr_pick #(.N(NREQ), .IW(IW)) u_pick (
    .req       (req_valid),
    .ptr       (pick_ptr),
    .winner    (pick_id),
    .any_valid (pick_any)
  );

  assign grant_inc = IW'(rr_next(int'(grant_id_raw), NREQ));

`ifdef DUP_ARB_BURST_EN
  localparam int CW = $clog2(MAX_BURST + 1);

  arb_state_t    state_reg, state_next;
  logic [IW-1:0] owner_reg, owner_next, owner_inc;
  logic [CW-1:0] burst_cnt_reg, burst_cnt_next, burst_cnt_inc;
  logic          in_lock, lock_hold;

  assign in_lock       = (state_reg == ARB_LOCK);
  assign lock_hold     = in_lock & req_valid[owner_reg];
  assign owner_inc     = IW'(rr_next(int'(owner_reg), NREQ));
  assign burst_cnt_inc = burst_cnt_reg + CW'(1);

  // A released lock arbitrates from owner+1 in the same cycle (no bubble).
  assign pick_ptr      = in_lock ? owner_inc : rr_ptr_reg;
  assign grant_raw     = lock_hold | pick_any;
  assign grant_id_raw  = lock_hold ? owner_reg : pick_id;

  // State register: pointer, lock state, owner and burst count.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_reg    <= '0;
      state_reg     <= ARB_IDLE;
      owner_reg     <= '0;
      burst_cnt_reg <= '0;
    end else begin
      rr_ptr_reg    <= rr_ptr_next;
      state_reg     <= state_next;
      owner_reg     <= owner_next;
      burst_cnt_reg <= burst_cnt_next;
    end
  end

  // Next-state logic; everything holds while the FIFO is full.
  always_comb begin
    state_next     = state_reg;
    owner_next     = owner_reg;
    burst_cnt_next = burst_cnt_reg;
    rr_ptr_next    = rr_ptr_reg;
    if (!fifo_full) begin
      if (lock_hold) begin
        // Owner word is accepted here; end the tenure at MAX_BURST words.
        if (burst_cnt_inc == CW'(MAX_BURST)) begin
          state_next     = ARB_IDLE;
          burst_cnt_next = '0;
          rr_ptr_next    = owner_inc;
        end else begin
          burst_cnt_next = burst_cnt_inc;
        end
      end else if (fifo_push) begin
        if (MAX_BURST > 1) begin
          state_next     = ARB_LOCK;
          owner_next     = grant_id_raw;
          burst_cnt_next = CW'(1);
        end else begin
          state_next     = ARB_IDLE;
          rr_ptr_next    = grant_inc;
        end
      end else if (in_lock) begin
        // Owner dropped and nobody else was ready: leave the lock behind.
        state_next     = ARB_IDLE;
        burst_cnt_next = '0;
        rr_ptr_next    = owner_inc;
      end
    end
  end
`else
  assign pick_ptr     = rr_ptr_reg;
  assign grant_raw    = pick_any;
  assign grant_id_raw = pick_id;

  // Pointer register.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_reg <= '0;
    end else begin
      rr_ptr_reg <= rr_ptr_next;
    end
  end

  // Advance past the winner on every accepted word.
  always_comb begin
    rr_ptr_next = rr_ptr_reg;
    if (fifo_push) begin
      rr_ptr_next = grant_inc;
    end
  end
`endif

  // Output logic: grant and handshake, all suppressed while in reset.
  always_comb begin
    grant_valid     = grant_raw & ~rst;
    grant_id        = grant_id_raw;
    fifo_push       = grant_valid & ~fifo_full;
    req_ready       = '0;
    if (fifo_push) begin
      req_ready[grant_id_raw] = 1'b1;
    end
    fifo_write_data = req_data[grant_id_raw];
  end

endmodule

// File: tb/tb_dup_fifo_wr_arb.sv
// Testbench for dup_fifo_wr_arb (NREQ=4, DW=16, MAX_BURST=3).
module tb_dup_fifo_wr_arb;

  localparam int N  = 4;
  localparam int DW = 16;
  localparam int MB = 3;
`ifdef DUP_ARB_BURST_EN
  localparam bit BURST = 1'b1;
`else
  localparam bit BURST = 1'b0;
`endif

  logic                  clk = 1'b0;
  logic                  rst;
  logic [N-1:0]          req_valid;
  logic [N-1:0][DW-1:0]  req_data;
  logic [N-1:0]          req_ready;
  logic                  fifo_push;
  logic [DW-1:0]         fifo_write_data;
  logic                  fifo_full;
  logic                  grant_valid;
  logic [1:0]            grant_id;

  dup_fifo_wr_arb #(.DW(DW), .NREQ(N), .MAX_BURST(MB)) dut (
    .clk             (clk),
    .rst             (rst),
    .req_valid       (req_valid),
    .req_data        (req_data),
    .req_ready       (req_ready),
    .fifo_push       (fifo_push),
    .fifo_write_data (fifo_write_data),
    .fifo_full       (fifo_full),
    .grant_valid     (grant_valid),
    .grant_id        (grant_id)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model state (spec-level view of the arbiter).
  int m_ptr   = 0;
  bit m_lock  = 0;
  int m_owner = 0;
  int m_cnt   = 0;

  // Captured DUT outputs from the most recent step.
  logic        cap_gv, cap_push;
  logic [1:0]  cap_gid;
  logic [3:0]  cap_ready;
  logic [15:0] cap_wdata;

  typedef struct {
    logic       rst;
    logic [3:0] valid;
    logic       full;
    logic       exp_gv;
    int         exp_gid;
    logic       exp_push;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void add(input logic r, input logic [3:0] v, input logic f,
                              input logic gv, input int gid, input logic p);
    vec_t e;
    e.rst = r; e.valid = v; e.full = f; e.exp_gv = gv; e.exp_gid = gid; e.exp_push = p;
    tbl.push_back(e);
  endfunction

  // One cycle: drive, compare against the model, clock, advance the model.
  task automatic step(input logic r, input logic [3:0] v, input logic [N-1:0][DW-1:0] d,
                      input logic f, input string tag);
    bit gv, push;
    int gid, p;
    logic [3:0] exp_ready;
    rst = r; req_valid = v; req_data = d; fifo_full = f;
    #2;
    gv = 0; gid = 0;
    if (!r) begin
      if (m_lock && v[m_owner]) begin
        gv = 1; gid = m_owner;
      end else begin
        p = m_lock ? (m_owner + 1) % N : m_ptr;
        for (int k = 0; k < N; k++) begin
          if (!gv && v[(p + k) % N]) begin
            gv = 1; gid = (p + k) % N;
          end
        end
      end
    end
    push = gv && !f;
    exp_ready = push ? (4'b0001 << gid) : 4'b0000;
    cap_gv = grant_valid; cap_push = fifo_push; cap_gid = grant_id;
    cap_ready = req_ready; cap_wdata = fifo_write_data;
    chk({tag, "_model_gv"}, 32'(grant_valid), 32'(gv));
    chk({tag, "_model_push"}, 32'(fifo_push), 32'(push));
    chk({tag, "_model_ready"}, 32'(req_ready), 32'(exp_ready));
    if (gv) chk({tag, "_model_gid"}, 32'(grant_id), 32'(gid));
    if (push) chk({tag, "_model_wdata"}, 32'(fifo_write_data), 32'(d[gid]));
    $display("%s: rst=%0b valid=%b full=%0b -> gv=%0b gid=%0d push=%0b ready=%b wdata=%h",
             tag, r, v, f, grant_valid, grant_id, fifo_push, req_ready, fifo_write_data);
    @(posedge clk);
    if (r) begin
      m_ptr = 0; m_lock = 0; m_owner = 0; m_cnt = 0;
    end else if (!f) begin
      if (m_lock && v[m_owner]) begin
        m_cnt++;
        if (m_cnt == MB) begin
          m_lock = 0; m_cnt = 0; m_ptr = (m_owner + 1) % N;
        end
      end else if (push) begin
        if (BURST && MB > 1) begin
          m_lock = 1; m_owner = gid; m_cnt = 1;
        end else begin
          m_lock = 0; m_ptr = (gid + 1) % N;
        end
      end else if (m_lock) begin
        m_lock = 0; m_cnt = 0; m_ptr = (m_owner + 1) % N;
      end
    end
    #1;
  endtask

  initial begin
    logic [N-1:0][DW-1:0] tdata;
    logic [N-1:0][DW-1:0] rd;
    logic [3:0]           er;
    logic [3:0]           rv;
    logic                 rf, rr;

    rst = 1'b1; req_valid = '0; req_data = '0; fifo_full = 1'b0;
    for (int i = 0; i < N; i++) tdata[i] = 16'h1000 + 16'(i);

    // Each producer offers one word; it drops valid once accepted.
    add(1, 4'b1111, 0, 0, -1, 0);
    add(0, 4'b1111, 0, 1, 0, 1);
    add(0, 4'b1110, 0, 1, 1, 1);
    add(0, 4'b1100, 0, 1, 2, 1);
    add(0, 4'b1000, 0, 1, 3, 1);
    add(0, 4'b0000, 0, 0, -1, 0);
    // Fairness with producers 1 and 3.
    add(1, 4'b0000, 0, 0, -1, 0);
`ifdef DUP_ARB_BURST_EN
    add(0, 4'b1010, 0, 1, 1, 1);
    add(0, 4'b1010, 0, 1, 1, 1);
    add(0, 4'b1010, 0, 1, 1, 1);
    add(0, 4'b1010, 0, 1, 3, 1);
    add(0, 4'b1010, 0, 1, 3, 1);
    add(0, 4'b1010, 0, 1, 3, 1);
    add(0, 4'b1010, 0, 1, 1, 1);
`else
    add(0, 4'b1010, 0, 1, 1, 1);
    add(0, 4'b1010, 0, 1, 3, 1);
    add(0, 4'b1010, 0, 1, 1, 1);
    add(0, 4'b1010, 0, 1, 3, 1);
    add(0, 4'b1010, 0, 1, 1, 1);
`endif
    // Full stall on producer 2, then release.
    add(1, 4'b0000, 0, 0, -1, 0);
    add(0, 4'b0100, 1, 1, 2, 0);
    add(0, 4'b0100, 1, 1, 2, 0);
    add(0, 4'b0100, 1, 1, 2, 0);
    add(0, 4'b0100, 0, 1, 2, 1);
`ifdef DUP_ARB_BURST_EN
    // All valid: tenures of MB words, with a reset mid-burst (owner 1, count 2).
    add(1, 4'b0000, 0, 0, -1, 0);
    add(0, 4'b1111, 0, 1, 0, 1);
    add(0, 4'b1111, 0, 1, 0, 1);
    add(0, 4'b1111, 0, 1, 0, 1);
    add(0, 4'b1111, 0, 1, 1, 1);
    add(0, 4'b1111, 0, 1, 1, 1);
    add(1, 4'b1111, 0, 0, -1, 0);
    add(0, 4'b1111, 0, 1, 0, 1);
    add(0, 4'b1111, 0, 1, 0, 1);
    add(0, 4'b1111, 0, 1, 0, 1);
    add(0, 4'b1111, 0, 1, 1, 1);
    add(0, 4'b1111, 0, 1, 1, 1);
    add(0, 4'b1111, 0, 1, 1, 1);
    add(0, 4'b1111, 0, 1, 2, 1);
    // Owner 0 drops after one word; producer 2 is granted with no bubble.
    add(1, 4'b0000, 0, 0, -1, 0);
    add(0, 4'b0101, 0, 1, 0, 1);
    add(0, 4'b0100, 0, 1, 2, 1);
    add(0, 4'b0101, 0, 1, 2, 1);
`else
    // All valid with a reset pulse after three words.
    add(1, 4'b0000, 0, 0, -1, 0);
    add(0, 4'b1111, 0, 1, 0, 1);
    add(0, 4'b1111, 0, 1, 1, 1);
    add(0, 4'b1111, 0, 1, 2, 1);
    add(1, 4'b1111, 0, 0, -1, 0);
    add(0, 4'b1111, 0, 1, 0, 1);
    add(0, 4'b1111, 0, 1, 1, 1);
`endif

    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].rst, tbl[i].valid, tdata, tbl[i].full, $sformatf("vec%0d", i));
      er = tbl[i].exp_push ? (4'b0001 << tbl[i].exp_gid) : 4'b0000;
      chk($sformatf("vec%0d_gv", i), 32'(cap_gv), 32'(tbl[i].exp_gv));
      chk($sformatf("vec%0d_push", i), 32'(cap_push), 32'(tbl[i].exp_push));
      chk($sformatf("vec%0d_ready", i), 32'(cap_ready), 32'(er));
      if (tbl[i].exp_gv)
        chk($sformatf("vec%0d_gid", i), 32'(cap_gid), 32'(tbl[i].exp_gid));
      if (tbl[i].exp_push)
        chk($sformatf("vec%0d_wdata", i), 32'(cap_wdata), 32'(16'h1000 + 16'(tbl[i].exp_gid)));
    end

    // Randomised traffic against the model.
    step(1, 4'b0000, tdata, 0, "rreset");
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++) rd[i] = 16'($urandom);
      rv = 4'($urandom);
      rf = ($urandom_range(0, 3) == 0);
      rr = ($urandom_range(0, 49) == 0);
      step(rr, rv, rd, rf, $sformatf("rnd%0d", c));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
